// File: rtl/axi_portal_master.sv
// axi_portal_master
//   AXI-style initiator for the portal bus. Takes one read or write command at
//   a time, issues the AR or AW/W burst, and returns R beats on rdata or the B
//   response on done. A stalled R/B phase is aborted after TIMEOUT idle cycles.
//
// Handshake rule for every ENA/RDY pair: a transfer happens on each rising
// edge where both are high. Every *__ENA this block drives is only ever high
// while its matching RDY is high.
//
// Ports
//   CLK, RST                        clock, synchronous active-high reset
//   cmd__*                          command in (write, byte addr, beats-1)
//   wdata__*                        write-data stream in
//   rdata__*                        read beat out (v, last, resp)
//   done__*                         write completion out (resp)
//   AR__*, AW__*, W__*              AXI request channels out
//   R__*, B__*                      AXI response channels in
//   state_dbg                       current FSM state, for observation
module axi_portal_master #(
  parameter logic [11:0] ID_BASE = 12'd0,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd__ENA,
  output logic        cmd__RDY,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wdata__ENA,
  output logic        wdata__RDY,
  input  logic [31:0] wdata_v,
  output logic        rdata__ENA,
  input  logic        rdata__RDY,
  output logic [31:0] rdata_v,
  output logic        rdata_last,
  output logic [1:0]  rdata_resp,
  output logic        done__ENA,
  input  logic        done__RDY,
  output logic [1:0]  done_resp,
  output logic        AR__ENA,
  input  logic        AR__RDY,
  output logic [31:0] AR_addr,
  output logic [11:0] AR_id,
  output logic [3:0]  AR_len,
  output logic        AW__ENA,
  input  logic        AW__RDY,
  output logic [31:0] AW_addr,
  output logic [11:0] AW_id,
  output logic [3:0]  AW_len,
  output logic        W__ENA,
  input  logic        W__RDY,
  output logic [31:0] W_data,
  output logic [11:0] W_id,
  output logic        W_last,
  input  logic        R__ENA,
  output logic        R__RDY,
  input  logic [31:0] R_data,
  input  logic [11:0] R_id,
  input  logic        R_last,
  input  logic [1:0]  R_resp,
  input  logic        B__ENA,
  output logic        B__RDY,
  input  logic [11:0] B_id,
  input  logic [1:0]  B_resp,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [31:0] addr;
  logic [3:0]  len, cnt;
  logic [11:0] id;
  logic [15:0] tmo;

  logic cnt_zero, tmo_hit, r_abort, b_abort, r_beat, b_beat, txn_done;

  assign cnt_zero  = (cnt == 4'd0);
  assign tmo_hit   = (TIMEOUT != 0) && (tmo == TMO_LIM);
  // A beat presented in the timeout cycle wins over the abort.
  assign r_abort   = (state == S_R) && tmo_hit && !R__ENA;
  assign b_abort   = (state == S_B) && tmo_hit && !B__ENA;
  assign r_beat    = R__ENA && R__RDY;
  assign b_beat    = B__ENA && B__RDY;
  // rdata/done fire exactly once per transaction end (normal or aborted).
  assign txn_done  = ((state == S_R) && rdata__ENA && (r_abort || cnt_zero)) ||
                     ((state == S_B) && done__ENA);
  assign state_dbg = state;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd__ENA && cmd__RDY) state_nxt = cmd_write ? S_AW : S_AR;
      S_AR:   if (AR__ENA) state_nxt = S_R;
      S_R:    if (txn_done) state_nxt = S_IDLE;
      S_AW:   if (AW__ENA) state_nxt = S_W;
      S_W:    if (W__ENA && cnt_zero) state_nxt = S_B;
      S_B:    if (txn_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs; everything is held at zero while reset is asserted.
  always_comb begin
    cmd__RDY = 1'b0; wdata__RDY = 1'b0;
    rdata__ENA = 1'b0; rdata_v = 32'd0; rdata_last = 1'b0; rdata_resp = 2'b00;
    done__ENA = 1'b0; done_resp = 2'b00;
    AR__ENA = 1'b0; AR_addr = 32'd0; AR_id = 12'd0; AR_len = 4'd0;
    AW__ENA = 1'b0; AW_addr = 32'd0; AW_id = 12'd0; AW_len = 4'd0;
    W__ENA = 1'b0; W_data = 32'd0; W_id = 12'd0; W_last = 1'b0;
    R__RDY = 1'b0; B__RDY = 1'b0;
    if (!RST) begin
      case (state)
        S_IDLE: cmd__RDY = 1'b1;
        S_AR: begin
          AR__ENA = AR__RDY; AR_addr = addr; AR_id = id; AR_len = len;
        end
        S_R: begin
          if (r_abort) begin
            rdata__ENA = rdata__RDY; rdata_last = 1'b1; rdata_resp = 2'b11;
          end else begin
            R__RDY     = rdata__RDY;
            rdata__ENA = R__ENA && rdata__RDY;
            rdata_v    = R_data;
            rdata_last = cnt_zero;
            rdata_resp = ((R_id != id) || (R_last != cnt_zero)) ? 2'b10 : R_resp;
          end
        end
        S_AW: begin
          AW__ENA = AW__RDY; AW_addr = addr; AW_id = id; AW_len = len;
        end
        S_W: begin
          wdata__RDY = W__RDY;
          W__ENA     = wdata__ENA && W__RDY;
          W_data     = wdata_v;
          W_id       = id;
          W_last     = cnt_zero;
        end
        S_B: begin
          if (b_abort) begin
            done__ENA = done__RDY; done_resp = 2'b11;
          end else begin
            B__RDY    = done__RDY;
            done__ENA = B__ENA && done__RDY;
            done_resp = (B_id != id) ? 2'b10 : B_resp;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= 32'd0;
      len  <= 4'd0;
      cnt  <= 4'd0;
      id   <= ID_BASE;
      tmo  <= 16'd0;
    end else begin
      if (cmd__ENA && cmd__RDY) begin
        addr <= cmd_addr;
        len  <= cmd_len;
        cnt  <= cmd_len;
      end
      if (((state == S_R && r_beat) || W__ENA) && !cnt_zero)
        cnt <= cnt - 4'd1;
      if (txn_done)
        id <= id + 12'd1;
      // tmo holds at the limit so an abort waiting on rdata/done stays put.
      if (AR__ENA || (state == S_R && r_beat) || (W__ENA && cnt_zero) ||
          (state == S_B && b_beat))
        tmo <= 16'd0;
      else if ((state == S_R || state == S_B) && TIMEOUT != 0 &&
               tmo != TMO_LIM && tmo != 16'hFFFF)
        tmo <= tmo + 16'd1;
    end
  end

endmodule
